// File: rtl/lut_loader_pkg.sv
// Shared constants and types for the runtime-loadable LUT neuron.
// Holds table geometry defaults, derived word/counter sizes and the loader FSM state.
package lut_loader_pkg;

  localparam int unsigned IN_BITS          = 8;
  localparam int unsigned OUT_BITS         = 2;
  localparam int unsigned WORD_W           = 32;

  localparam int unsigned DEPTH            = 1 << IN_BITS;
  localparam int unsigned TBL_W            = DEPTH * OUT_BITS;
  localparam int unsigned TBL_IDX_W        = $clog2(TBL_W);
  localparam int unsigned ENTRIES_PER_WORD = WORD_W / OUT_BITS;
  localparam int unsigned NUM_WORDS        = DEPTH / ENTRIES_PER_WORD;
  localparam int unsigned CNT_W            = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SWAP = 2'd2
  } state_e;

endpackage

// File: rtl/lut_table_bank.sv
// One table bank: DEPTH x OUT_BITS flops with a word write port, a full
// parallel-load port and a combinational entry read mux.
// Ports:
//   clk        clock
//   wr_en      write wr_data into word slot wr_idx
//   wr_idx     word slot (covers entries ENTRIES_PER_WORD*wr_idx upward)
//   wr_data    packed entries, entry j at bits [OUT_BITS*j +: OUT_BITS]
//   load_en    replace the whole table with load_data (wins over wr_en)
//   load_data  full table image
//   rd_addr    entry index for the read mux
//   rd_data_c  entry at rd_addr (combinational)
//   table_q    full table image (registered contents)
module lut_table_bank
  import lut_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [CNT_W-1:0]      wr_idx,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  load_en,
  input  logic [TBL_W-1:0]      load_data,
  input  logic [IN_BITS-1:0]    rd_addr,
  output logic [OUT_BITS-1:0]   rd_data_c,
  output logic [TBL_W-1:0]      table_q
);

  logic [TBL_W-1:0]     table_d;
  logic [TBL_IDX_W-1:0] wr_base;
  logic [TBL_IDX_W-1:0] rd_base;

  // Entries are stored contiguously, so word k starts at bit WORD_W*k.
  always_comb begin
    wr_base = TBL_IDX_W'(wr_idx) * TBL_IDX_W'(WORD_W);
    rd_base = TBL_IDX_W'(rd_addr) * TBL_IDX_W'(OUT_BITS);
  end

  // Next contents: parallel load has priority over a word write.
  always_comb begin
    table_d = table_q;
    if (load_en) begin
      table_d = load_data;
    end else if (wr_en) begin
      table_d[wr_base +: WORD_W] = wr_data;
    end
  end

  // Contents are deliberately not reset; the owner gates them with a valid flag.
  always_ff @(posedge clk) begin
    table_q <= table_d;
  end

  assign rd_data_c = table_q[rd_base +: OUT_BITS];

endmodule

// File: rtl/lut_table_loader.sv
// Runtime-writable truth-table neuron. A table is streamed word by word into a
// shadow bank and swapped atomically into the active bank; a registered lookup
// port maps M0 to M1 from the active bank.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cfg_start    begin or restart a table load
//   cfg_data     packed table entries, cfg_valid qualifies
//   cfg_ready    loader accepts a word this cycle (state decode only)
//   cfg_done     one-cycle pulse when a new table becomes active
//   table_ok     active bank holds a completely loaded table
//   in_valid, M0 lookup request and address
//   out_valid, M1 registered lookup result (M1 holds when no request)
module lut_table_loader
  import lut_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic                cfg_done,
  output logic                table_ok,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  M0,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] M1
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                cfg_done_q, cfg_done_d;
  logic                table_ok_q, table_ok_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0] m1_q, m1_d;

  logic                shd_wr_en_c;
  logic                act_load_c;
  logic [TBL_W-1:0]    shd_table;
  logic [OUT_BITS-1:0] act_rd_c;
  logic [OUT_BITS-1:0] shd_rd_unused_c;
  logic [TBL_W-1:0]    act_table_unused;

  // Shadow bank: filled word by word during LOAD.
  lut_table_bank u_shadow (
    .clk       (clk),
    .wr_en     (shd_wr_en_c),
    .wr_idx    (cnt_q),
    .wr_data   (cfg_data),
    .load_en   (1'b0),
    .load_data ({TBL_W{1'b0}}),
    .rd_addr   (M0),
    .rd_data_c (shd_rd_unused_c),
    .table_q   (shd_table)
  );

  // Active bank: only ever replaced as a whole from the shadow.
  lut_table_bank u_active (
    .clk       (clk),
    .wr_en     (1'b0),
    .wr_idx    ({CNT_W{1'b0}}),
    .wr_data   ({WORD_W{1'b0}}),
    .load_en   (act_load_c),
    .load_data (shd_table),
    .rd_addr   (M0),
    .rd_data_c (act_rd_c),
    .table_q   (act_table_unused)
  );

  // Loader FSM next state, word counter and bank controls.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cfg_done_d  = 1'b0;
    table_ok_d  = table_ok_q;
    shd_wr_en_c = 1'b0;
    act_load_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        // A restart drops any word offered in the same cycle.
        if (cfg_start) begin
          cnt_d = '0;
        end else if (cfg_valid) begin
          shd_wr_en_c = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_WORD) begin
            state_d = SWAP;
          end
        end
      end
      SWAP: begin
        act_load_c = 1'b1;
        table_ok_d = 1'b1;
        cfg_done_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Registered decode of the next state keeps cfg_valid out of cfg_ready.
    cfg_ready_d = (state_d == LOAD);
  end

  // Lookup register: result updates on a request, holds otherwise.
  always_comb begin
    out_valid_d = in_valid;
    m1_d        = m1_q;
    if (in_valid) begin
      m1_d = table_ok_q ? act_rd_c : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cfg_ready_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      table_ok_q  <= 1'b0;
      out_valid_q <= 1'b0;
      m1_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_done_q  <= cfg_done_d;
      table_ok_q  <= table_ok_d;
      out_valid_q <= out_valid_d;
      m1_q        <= m1_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_done  = cfg_done_q;
  assign table_ok  = table_ok_q;
  assign out_valid = out_valid_q;
  assign M1        = m1_q;

endmodule

// File: tb/tb_lut_table_loader.sv
// Self-checking bench for lut_table_loader: lookup expectations are queued at
// the sampling edge from a transaction-level table model and compared when the
// DUT presents out_valid; loader flags are compared every cycle.
module tb_lut_table_loader;
  import lut_loader_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_start = 1'b0;
  logic [WORD_W-1:0]   cfg_data = '0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic                cfg_done;
  logic                table_ok;
  logic                in_valid = 1'b0;
  logic [IN_BITS-1:0]  M0 = '0;
  logic                out_valid;
  logic [OUT_BITS-1:0] M1;

  lut_table_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .table_ok  (table_ok),
    .in_valid  (in_valid),
    .M0        (M0),
    .out_valid (out_valid),
    .M1        (M1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int done_seen = 0;
  int loads_done = 0;

  // Table model
  logic [OUT_BITS-1:0] shd_m [DEPTH];
  logic [OUT_BITS-1:0] act_m [DEPTH];
  logic [OUT_BITS-1:0] exp_q [$];
  logic ok_m = 1'b0, swap_pend = 1'b0, exp_done = 1'b0, ready_m = 1'b0, exp_ov = 1'b0;
  logic last_drv = 1'b0;
  logic [OUT_BITS-1:0] m1_exp = '0;

  // Lookup stimulus modes: 0 none, 1 fixed lk_addr, 2 random, 3 address sweep
  int                 lk_mode = 0;
  logic [IN_BITS-1:0] lk_addr = '0;
  logic [IN_BITS-1:0] sweep_a = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    case (lk_mode)
      1: begin in_valid = 1'b1; M0 = lk_addr; end
      2: begin in_valid = 1'($urandom_range(0, 1)); M0 = IN_BITS'($urandom); end
      3: begin in_valid = 1'b1; M0 = sweep_a; sweep_a = sweep_a + 1'b1; end
      default: begin in_valid = 1'b0; sweep_a = '0; end
    endcase
  end

  // Model: what each edge should do, from the bench's own knowledge of the stimulus.
  always @(posedge clk) begin
    if (!rst_n) begin
      ok_m = 1'b0; swap_pend = 1'b0; exp_done = 1'b0; ready_m = 1'b0; exp_ov = 1'b0;
    end else begin
      if (in_valid) exp_q.push_back(ok_m ? act_m[M0] : 2'b00);
      exp_ov   = in_valid;
      exp_done = 1'b0;
      if (swap_pend) begin
        act_m = shd_m; ok_m = 1'b1; exp_done = 1'b1; swap_pend = 1'b0;
      end
      if (cfg_start) ready_m = 1'b1;
      if (last_drv) begin swap_pend = 1'b1; ready_m = 1'b0; end
    end
  end

  // Monitor: compare DUT outputs shortly after each edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin exp_q.delete(); m1_exp = '0; end
    check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
    check_eq("table_ok", 32'(table_ok), 32'(ok_m));
    check_eq("cfg_done", 32'(cfg_done), 32'(exp_done));
    check_eq("cfg_ready", 32'(cfg_ready), 32'(ready_m));
    if (out_valid) begin
      if (exp_q.size() == 0) check_eq("sb_depth", 32'(exp_q.size()), 32'd1);
      else m1_exp = exp_q.pop_front();
    end
    check_eq("M1", 32'(M1), 32'(m1_exp));
    if (cfg_done === 1'b1) done_seen++;
  end

  task automatic cyc(input logic st, input logic v, input logic [WORD_W-1:0] d, input logic last);
    cfg_start = st; cfg_valid = v; cfg_data = d; last_drv = last;
    @(negedge clk);
  endtask

  function automatic logic [WORD_W-1:0] mk_word(input int fill);
    case (fill)
      0: return 32'hE4E4E4E4;
      1: return 32'hFFFFFFFF;
      2: return 32'h55555555;
      default: return WORD_W'($urandom);
    endcase
  endfunction

  // Full or partial load. restart_at: words before a mid-load restart (-1 none).
  // stop_at: words after which the task returns without finishing (-1 none).
  task automatic do_load(input int fill, input bit gaps, input int restart_at, input int stop_at);
    logic [WORD_W-1:0] w;
    bit v;
    int k = 0;
    bit restarted = 1'b0;
    cyc(1'b1, 1'b0, '0, 1'b0);
    while (k < int'(NUM_WORDS)) begin
      if (!restarted && k == restart_at) begin
        cyc(1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        restarted = 1'b1;
        k = 0;
      end else if (k == stop_at) begin
        break;
      end else begin
        v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        w = mk_word(fill);
        if (v) begin
          for (int j = 0; j < int'(ENTRIES_PER_WORD); j++)
            shd_m[k * int'(ENTRIES_PER_WORD) + j] = w[OUT_BITS * j +: OUT_BITS];
        end
        cyc(1'b0, v, w, v && (k == int'(NUM_WORDS) - 1));
        if (v) k++;
      end
    end
    cyc(1'b0, 1'b0, '0, 1'b0);
    if (k == int'(NUM_WORDS)) loads_done++;
    repeat (3) cyc(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic sweep();
    lk_mode = 3;
    repeat (260) @(negedge clk);
    lk_mode = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Lookup before any table is loaded reads as zero.
    lk_addr = 8'hA5; lk_mode = 1;
    @(negedge clk);
    lk_mode = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_table_ok", 32'(table_ok), 32'd0);
    check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd0);

    // Identity-of-low-bits table, then full sweep.
    do_load(0, 1'b0, -1, -1);
    sweep();

    // All-3 table, then reload all-1 under a continuous lookup stream.
    do_load(1, 1'b0, -1, -1);
    lk_addr = 8'h3C; lk_mode = 1;
    do_load(2, 1'b0, -1, -1);
    lk_mode = 0;
    repeat (2) @(negedge clk);

    // Mid-load restart after 7 words, random lookups running.
    lk_mode = 2;
    do_load(3, 1'b0, 7, -1);
    lk_mode = 0;
    sweep();

    // Asynchronous reset after 10 of 16 words while lookups are active.
    lk_addr = 8'h11; lk_mode = 1;
    do_load(3, 1'b0, -1, 10);
    rst_n = 1'b0;
    #1;
    check_eq("arst_table_ok", 32'(table_ok), 32'd0);
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_M1", 32'(M1), 32'd0);
    check_eq("arst_cfg_ready", 32'(cfg_ready), 32'd0);
    lk_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_load(3, 1'b0, -1, -1);
    sweep();

    // Bursty cfg_valid with random lookups.
    lk_mode = 2;
    do_load(3, 1'b1, -1, -1);
    lk_mode = 0;
    sweep();

    repeat (3) @(negedge clk);
    check_eq("done_count", 32'(done_seen), 32'(loads_done));
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lut_table_loader.md
# lut_table_loader

Runtime-writable counterpart of the fixed truth-table neurons. Instead of a synthesized ROM, the neuron table (2^IN_BITS entries of OUT_BITS each) is streamed in over a word-wide configuration port into a shadow bank. On completion it is atomically swapped into the active bank. A registered lookup port on the active bank presents the same M0 to M1 mapping a hardwired neuron would, so the block can stand in for any layer neuron during bring-up and for weight updates without re-synthesis.

## Interface
- IN_BITS, 8, lookup address width; table depth 2^IN_BITS
- OUT_BITS, 2, entry width
- WORD_W, 32, configuration word width; ENTRIES_PER_WORD = WORD_W/OUT_BITS (16); NUM_WORDS = 2^IN_BITS/ENTRIES_PER_WORD (16)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_start  in  1  begin or restart a table load
- cfg_data  in  WORD_W  packed table entries
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  loader accepts a word this cycle
- cfg_done  out  1  one-cycle pulse when the new table becomes active
- table_ok  out  1  active bank holds a completely loaded table
- in_valid  in  1  lookup request
- M0  in  IN_BITS  lookup address (concatenated neuron inputs)
- out_valid  out  1  M1 valid
- M1  out  OUT_BITS  looked-up entry

## Operation
- FSM states: IDLE, LOAD, SWAP.
- IDLE: cfg_ready=0. cfg_start moves to LOAD, with word counter set to 0.
- LOAD: cfg_ready=1. A word is accepted when cfg_valid & cfg_ready.
  - Word k writes shadow entries 16k..16k+15; entry j is cfg_data[OUT_BITS*j +: OUT_BITS].
  - The counter increments per accepted word. Acceptance of word NUM_WORDS-1 moves to SWAP.
- SWAP (one cycle): cfg_ready=0. On exit edge: active bank := shadow, table_ok := 1, state := IDLE. cfg_done is high for the cycle following that edge.
- cfg_start during LOAD: counter := 0 and any word offered the same cycle is dropped. Shadow contents are overwritten as the reload proceeds. Active bank is untouched.
- cfg_start in SWAP: ignored; the swap completes.
- cfg_start and cfg_valid together in IDLE: enter LOAD; the word is not accepted.
- Lookup runs in every state:
  - out_valid <= in_valid.
  - M1 <= table_ok ? active[M0] : 0.
  - M0 is an unsigned index.
  - M1 updates only when in_valid=1; it holds otherwise.
- Reset (async, any state, including mid-load):
  - state=IDLE, counter=0, cfg_ready=0, cfg_done=0, table_ok=0, out_valid=0, M1=0.
  - Bank contents are not reset; table_ok gates them.

## Timing
- Lookup latency 1 cycle: M0/in_valid sampled at edge t; M1/out_valid valid after edge t.
- Load throughput 1 word/cycle. Minimum load: 1 (start) + NUM_WORDS + 1 (SWAP) = 18 cycles from cfg_start edge to table_ok.
- Last word accepted at edge N:
  - SWAP occupies the cycle after N; active updates at edge N+1.
  - Lookups sampled at or before edge N+1 use the old table; lookups from edge N+2 use the new table.
  - cfg_done is high between edges N+1 and N+2.
- cfg_ready is a function of state only (no combinational path from cfg_valid).

## Structure
- Shared package lut_loader_pkg holds:
  - IN_BITS, OUT_BITS, WORD_W defaults
  - derived ENTRIES_PER_WORD, NUM_WORDS, counter width
  - state enum (IDLE, LOAD, SWAP)
- One sub-module, lut_table_bank:
  - flop array of 2^IN_BITS x OUT_BITS with word-write port (index, data, enable), full parallel-load port, and combinational read mux.
  - Instantiated twice (shadow, active).
- Top level holds the FSM, counter, lookup register and done/ok flags. Target 200-300 lines total.

## Test plan
- Reset then lookup M0=8'hA5 with in_valid=1 -> out_valid=1 next cycle, M1=2'b00, table_ok=0, cfg_ready=0.
- cfg_start, then 16 words with entry value = addr[1:0] (each word 32'hE4E4E4E4), cfg_valid held high -> cfg_done 18 cycles after start; then sweep M0=0..255 -> M1=M0[1:0] each one cycle later.
- Load all-2'b11 table (words 32'hFFFFFFFF), then reload all-2'b01 (32'h55555555) with a continuous lookup stream at M0=8'h3C -> M1=2'b11 for lookups sampled up to edge N+1, 2'b01 from edge N+2, no other value.
- Mid-load cfg_start after 7 words, then 16 fresh words -> only one cfg_done, table reflects the fresh words exactly; the word offered with cfg_start is dropped.
- Assert rst_n low after 10 of 16 words -> table_ok=0, out_valid=0, M1=0 immediately (asynchronous). A subsequent complete load restores correct lookups.
- cfg_valid toggled randomly with gaps during a load -> exactly 16 accepted words, cfg_ready never high in IDLE or SWAP, cfg_done exactly once.
